// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port bus arbiter for fetch and load/store, data first, with ack timeout.
module mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iread,
   input  logic [ADDR_W-1:0] iaddr,
   input  logic              dread,
   input  logic              dwrite,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dwdata,
   input  logic [3:0]        dsel,
   output logic              iready,
   output logic [DATA_W-1:0] instr,
   output logic              dready,
   output logic [DATA_W-1:0] drdata,
   output logic              fault,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_re,
   output logic              bus_we,
   output logic [DATA_W-1:0] bus_wdata,
   output logic [3:0]        bus_sel,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata
);
   localparam logic [1:0] S_IDLE = 2'd0, S_IACC = 2'd1, S_DACC = 2'd2, S_RESP = 2'd3;
   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [3:0]        r_sel;
   logic [7:0]        r_cnt;
   logic              r_we, r_dual, r_data, r_fault;
   logic [DATA_W-1:0] r_instr, r_drdata;
   logic              w_acc, w_resp, w_expire;
   assign w_acc    = (r_state == S_IACC) | (r_state == S_DACC);
   assign w_resp   = r_state == S_RESP;
   // ack in the expiry cycle takes precedence over the timeout
   assign w_expire = w_acc & ~bus_ack & (r_cnt == 8'(TIMEOUT_CYC - 1));
   assign bus_re    = w_acc & ~r_we;
   assign bus_we    = w_acc & r_we;
   assign bus_addr  = r_addr;
   assign bus_wdata = r_wdata;
   assign bus_sel   = r_sel;
   assign iready    = w_resp & ~r_data;
   assign dready    = w_resp & r_data & ~r_dual;
   assign fault     = w_resp & r_fault;
   assign instr     = r_instr;
   assign drdata    = r_drdata;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_sel    <= '0;
         r_cnt    <= '0;
         r_we     <= 1'b0;
         r_dual   <= 1'b0;
         r_data   <= 1'b0;
         r_fault  <= 1'b0;
         r_instr  <= '0;
         r_drdata <= '0;
      end else if (r_state == S_IDLE) begin
         r_cnt   <= '0;
         r_fault <= 1'b0;
         if (dread | dwrite) begin
            r_addr  <= daddr;
            r_wdata <= dwdata;
            r_sel   <= dwrite ? dsel : 4'hF;
            r_we    <= dwrite;
            r_dual  <= dread & dwrite;
            r_data  <= 1'b1;
            r_state <= S_DACC;
         end else if (iread) begin
            r_addr  <= iaddr;
            r_sel   <= 4'hF;
            r_we    <= 1'b0;
            r_dual  <= 1'b0;
            r_data  <= 1'b0;
            r_state <= S_IACC;
         end
      end else if (w_acc) begin
         if (bus_ack | w_expire) begin
            r_state <= S_RESP;
            r_fault <= w_expire;
            if (!r_data)
               r_instr <= bus_ack ? bus_rdata : '0;
            else if (!r_we)
               r_drdata <= bus_ack ? bus_rdata : '0;
         end else
            r_cnt <= r_cnt + 8'd1;
      end else
         r_state <= S_IDLE;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with expected responses queued and checked by monitors.
module tb_mem_arbiter;
   typedef struct packed {logic d; logic [31:0] data; logic f;} exp_t;
   logic clk = 1'b0, rst = 1'b1;
   logic iread = 0, dread = 0, dwrite = 0, bus_ack = 0;
   logic [31:0] iaddr = 0, daddr = 0, dwdata = 0, bus_rdata = 0;
   logic [3:0] dsel = 0;
   logic iready, dready, fault, bus_re, bus_we;
   logic [31:0] instr, drdata, bus_addr, bus_wdata;
   logic [3:0] bus_sel;
   logic b_iread = 0, b_ack = 0;
   logic [31:0] b_iaddr = 0, b_rdata = 0;
   logic b_iready, b_dready, b_fault, b_bus_re, b_bus_we;
   logic [31:0] b_instr, b_drdata, b_bus_addr, b_bus_wdata;
   logic [3:0] b_bus_sel;
   int checks = 0, errors = 0;
   exp_t qa[$], qb[$];
   always #5 clk = ~clk;
   mem_arbiter u_dut (
      .clk(clk), .rst(rst), .iread(iread), .iaddr(iaddr), .dread(dread), .dwrite(dwrite),
      .daddr(daddr), .dwdata(dwdata), .dsel(dsel), .iready(iready), .instr(instr),
      .dready(dready), .drdata(drdata), .fault(fault), .bus_addr(bus_addr), .bus_re(bus_re),
      .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_sel(bus_sel), .bus_ack(bus_ack),
      .bus_rdata(bus_rdata));
   mem_arbiter #(.TIMEOUT_CYC(4)) u_to (
      .clk(clk), .rst(rst), .iread(b_iread), .iaddr(b_iaddr), .dread(1'b0), .dwrite(1'b0),
      .daddr(32'h0), .dwdata(32'h0), .dsel(4'h0), .iready(b_iready), .instr(b_instr),
      .dready(b_dready), .drdata(b_drdata), .fault(b_fault), .bus_addr(b_bus_addr),
      .bus_re(b_bus_re), .bus_we(b_bus_we), .bus_wdata(b_bus_wdata), .bus_sel(b_bus_sel),
      .bus_ack(b_ack), .bus_rdata(b_rdata));
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (iready | dready) begin
         if (qa.size() == 0) chk("a_unexpected_ready", {iready, dready}, 2'b00);
         else begin
            e = qa.pop_front();
            chk("a_resp", {dready, iready, dready ? drdata : instr, fault}, {e.d, ~e.d, e.data, e.f});
         end
      end
   end
   always @(negedge clk) begin
      exp_t e;
      if (b_iready | b_dready) begin
         if (qb.size() == 0) chk("b_unexpected_ready", {b_iready, b_dready}, 2'b00);
         else begin
            e = qb.pop_front();
            chk("b_resp", {b_dready, b_iready, b_instr, b_fault}, {e.d, ~e.d, e.data, e.f});
         end
      end
   end
   // acks the n-th strobe cycle, checking bus fields on every strobe cycle and the grant latency
   task automatic serve(input int n, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] sel, input logic [31:0] rd, input logic rdy, input int lat_exp);
      int seen = 0, lat = -1;
      for (int t = 0; t < 300 && seen < n; t++) begin
         @(negedge clk);
         if (bus_re | bus_we) begin
            if (lat < 0) lat = t;
            seen++;
            chk("strobe", {bus_we, bus_re, bus_addr, bus_sel, we ? bus_wdata : 32'h0},
                {we, ~we, addr, we ? sel : 4'hF, we ? wd : 32'h0});
            if (seen == n) begin
               bus_ack = 1'b1;
               bus_rdata = rd;
            end
         end
      end
      chk("grant_latency", lat, lat_exp);
      @(negedge clk);
      bus_ack = 1'b0;
      chk("resp_cycle", {bus_re, bus_we, iready | dready}, {2'b00, rdy});
   endtask
   initial begin
      int cnt;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {iready, dready, fault, bus_re, bus_we, instr, drdata, bus_addr, bus_sel},
          '0);
      rst = 1'b0;
      @(negedge clk);
      iread = 1; iaddr = 32'h100;
      qa.push_back('{1'b0, 32'h93, 1'b0});
      serve(1, 0, 32'h100, 0, 0, 32'h93, 1, 0);
      iread = 0;
      @(negedge clk);
      iread = 1; iaddr = 32'h104; dread = 1; daddr = 32'h2000;
      qa.push_back('{1'b1, 32'hCAFE0001, 1'b0});
      qa.push_back('{1'b0, 32'h13, 1'b0});
      serve(1, 0, 32'h2000, 0, 0, 32'hCAFE0001, 1, 0);
      dread = 0;
      serve(1, 0, 32'h104, 0, 0, 32'h13, 1, 1);
      iread = 0;
      @(negedge clk);
      dwrite = 1; daddr = 32'h3000; dwdata = 32'hDEADBEEF; dsel = 4'b0011;
      qa.push_back('{1'b1, 32'hCAFE0001, 1'b0});
      serve(5, 1, 32'h3000, 32'hDEADBEEF, 4'b0011, 32'hFFFF, 1, 0);
      dwrite = 0;
      @(negedge clk);
      iread = 1; iaddr = 32'h200;
      qa.push_back('{1'b0, 32'h55, 1'b0});
      @(negedge clk);
      chk("drop_granted", {bus_re, bus_addr}, {1'b1, 32'h200});
      iread = 0;
      serve(2, 0, 32'h200, 0, 0, 32'h55, 1, 0);
      @(negedge clk);
      dread = 1; dwrite = 1; daddr = 32'h4000; dwdata = 32'h1234; dsel = 4'hC;
      serve(1, 1, 32'h4000, 32'h1234, 4'hC, 32'h9999, 0, 0);
      dread = 0; dwrite = 0;
      @(negedge clk);
      chk("data_after_dual", {instr, drdata}, {32'h55, 32'hCAFE0001});
      dread = 1; daddr = 32'h5000;
      @(negedge clk);
      chk("dacc_before_reset", {bus_re, bus_addr}, {1'b1, 32'h5000});
      rst = 1; dread = 0;
      @(negedge clk);
      chk("after_mid_reset", {bus_re, bus_we, dready, iready, instr, drdata}, '0);
      rst = 0;
      iread = 1; iaddr = 32'h600;
      qa.push_back('{1'b0, 32'h77, 1'b0});
      serve(1, 0, 32'h600, 0, 0, 32'h77, 1, 0);
      iread = 0;
      b_iread = 1; b_iaddr = 32'h800;
      qb.push_back('{1'b0, 32'hABCD0123, 1'b0});
      cnt = 0;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (b_bus_re) begin
            cnt++;
            if (cnt == 4) begin
               b_ack = 1; b_rdata = 32'hABCD0123;
               break;
            end
         end
      end
      chk("ack_at_expiry_cycles", cnt, 4);
      @(negedge clk);
      b_ack = 0; b_iread = 0;
      chk("ack_at_expiry_resp", {b_iready, b_fault, b_instr}, {1'b1, 1'b0, 32'hABCD0123});
      @(negedge clk);
      b_iread = 1; b_iaddr = 32'h700;
      qb.push_back('{1'b0, 32'h0, 1'b1});
      cnt = 0;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (b_bus_re) begin
            chk("timeout_addr", b_bus_addr, 32'h700);
            cnt++;
         end else if (cnt > 0) break;
      end
      b_iread = 0;
      chk("timeout_strobe_cycles", cnt, 4);
      chk("timeout_resp", {b_iready, b_fault, b_instr}, {1'b1, 1'b1, 32'h0});
      b_ack = 1; b_rdata = 32'h5555;
      repeat (3) @(negedge clk);
      b_ack = 0;
      chk("late_ack_ignored", {b_bus_re, b_instr}, {1'b0, 32'h0});
      repeat (3) @(negedge clk);
      chk("queues_drained", {qa.size(), qb.size()}, 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
